// File: rtl/pending_encoder_8_3_if.sv
// Handshake bundle for the sequential 8:3 pending encoder:
// request load side plus the code valid/ready stream.
interface pending_encoder_8_3_if #(
  parameter int N_IN   = 8,
  parameter int CODE_W = 3
);
  logic [N_IN-1:0]   d_in;
  logic              load;
  logic              load_ready;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              code_ready;
  logic              done;
  logic [CODE_W:0]   count;

  modport master (
    output d_in,
    output load,
    output code_ready,
    input  load_ready,
    input  code_out,
    input  code_valid,
    input  done,
    input  count
  );

  modport slave (
    input  d_in,
    input  load,
    input  code_ready,
    output load_ready,
    output code_out,
    output code_valid,
    output done,
    output count
  );
endinterface

// File: rtl/pending_encoder_8_3.sv
// Sequential 8:3 priority encoder draining a multi-hot word as indices.
// Define PENC_ROUND_ROBIN_EN for rotating-pointer search order.
module pending_encoder_8_3 #(
  parameter int N_IN   = 8,
  parameter int CODE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pending_encoder_8_3_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_IN-1:0]   r_pending;
  logic [N_IN-1:0]   w_pend_nxt;
  logic [CODE_W:0]   r_count;
  logic [CODE_W:0]   w_count_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_xfer;
  logic              w_last;
  logic [CODE_W-1:0] w_start_ld;
  logic [CODE_W-1:0] w_start_dr;

  // First set bit found searching downward from start, wrapping.
  function automatic logic [CODE_W-1:0] f_sel(
    input logic [N_IN-1:0]   v,
    input logic [CODE_W-1:0] start
  );
    logic [CODE_W-1:0] idx;
    logic              found;
    f_sel = '0;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = start - CODE_W'(k);
      if (!found && v[idx]) begin
        f_sel = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [CODE_W:0] f_pop(
    input logic [N_IN-1:0] v
  );
    f_pop = '0;
    for (int i = 0; i < N_IN; i++) begin
      f_pop = f_pop + {{CODE_W{1'b0}}, v[i]};
    end
  endfunction

  assign w_xfer = (r_state == S_DRAIN)
                & bus.code_ready;
  assign w_last = (r_count == (CODE_W+1)'(1));

`ifdef PENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] r_ptr;
  logic [CODE_W-1:0] w_ptr_nxt;

  assign w_ptr_nxt  = w_xfer
                    ? r_code - CODE_W'(1)
                    : r_ptr;
  assign w_start_ld = r_ptr;
  assign w_start_dr = w_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '1;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  assign w_start_ld = '1;
  assign w_start_dr = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.load && (|bus.d_in)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_xfer && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pend_nxt  = r_pending;
    w_count_nxt = r_count;
    w_code_nxt  = r_code;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.load) begin
          if (|bus.d_in) begin
            w_pend_nxt  = bus.d_in;
            w_count_nxt = f_pop(bus.d_in);
            w_code_nxt  = f_sel(bus.d_in,
                                w_start_ld);
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_xfer) begin
          w_pend_nxt  = r_pending
                      & ~(N_IN'(1) << r_code);
          w_count_nxt = r_count
                      - (CODE_W+1)'(1);
          // Park code at 0 once the word is empty.
          w_code_nxt  = w_last
                      ? '0
                      : f_sel(w_pend_nxt,
                              w_start_dr);
          w_done_nxt  = w_last;
        end
      end
      default: begin
        w_pend_nxt  = '0;
        w_count_nxt = '0;
        w_code_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_count   <= '0;
      r_code    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_count   <= w_count_nxt;
      r_code    <= w_code_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.code_valid = (r_state == S_DRAIN);
  assign bus.code_out   = r_code;
  assign bus.done       = r_done;
  assign bus.count      = r_count;

endmodule

// File: tb/tb_pending_encoder_8_3.sv
// Directed bench for pending_encoder_8_3; expectations track
// PENC_ROUND_ROBIN_EN where search order differs.
module tb_pending_encoder_8_3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pending_encoder_8_3_if #(
    .N_IN   (8),
    .CODE_W (3)
  ) bus ();

  pending_encoder_8_3 #(
    .N_IN   (8),
    .CODE_W (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.d_in       = '0;
    bus.load       = 1'b0;
    bus.code_ready = 1'b0;
    #3;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_lr got=%b exp=1",
               bus.load_ready);
    end
    checks++;
    if (bus.code_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=0",
               bus.code_valid);
    end
    checks++;
    if (bus.code_out !== 3'd0) begin
      errors++;
      $display("FAIL rst_code got=%0d exp=0",
               bus.code_out);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0",
               bus.done);
    end
    checks++;
    if (bus.count !== 4'd0) begin
      errors++;
      $display("FAIL rst_count got=%0d exp=0",
               bus.count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fixed_order();
    logic [2:0] exp_c [4];
    exp_c = '{3'd7, 3'd5, 3'd2, 3'd0};
    bus.code_ready = 1'b1;
    bus.d_in       = 8'b1010_0101;
    bus.load       = 1'b1;
    step();
    bus.load = 1'b0;
    bus.d_in = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.code_valid !== 1'b1 ||
          bus.code_out !== exp_c[i]) begin
        errors++;
        $display("FAIL a5_code[%0d] got=%b/%0d exp=1/%0d",
                 i, bus.code_valid, bus.code_out,
                 exp_c[i]);
      end
      checks++;
      if (bus.count !== 4'(4 - i)) begin
        errors++;
        $display("FAIL a5_count[%0d] got=%0d exp=%0d",
                 i, bus.count, 4 - i);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.load_ready !== 1'b1 ||
        bus.code_valid !== 1'b0) begin
      errors++;
      $display("FAIL a5_done got=%b%b%b exp=110",
               bus.done, bus.load_ready, bus.code_valid);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL a5_done_pulse got=%b exp=0",
               bus.done);
    end
  endtask

  task automatic test_all_ones();
    bus.code_ready = 1'b1;
    bus.d_in       = 8'hFF;
    bus.load       = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.code_valid !== 1'b1 ||
          bus.code_out !== 3'(7 - i) ||
          bus.count !== 4'(8 - i)) begin
        errors++;
        $display("FAIL ff[%0d] got=%b/%0d/%0d exp=1/%0d/%0d",
                 i, bus.code_valid, bus.code_out,
                 bus.count, 7 - i, 8 - i);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL ff_done got=%b/%0d exp=1/0",
               bus.done, bus.count);
    end
    step();
  endtask

  task automatic test_empty();
    bus.d_in = 8'h00;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.code_valid !== 1'b0 ||
        bus.count !== 4'd0) begin
      errors++;
      $display("FAIL empty got=%b/%b/%0d exp=1/0/0",
               bus.done, bus.code_valid, bus.count);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.code_valid !== 1'b0 ||
        bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_after got=%b/%b/%b exp=0/0/1",
               bus.done, bus.code_valid, bus.load_ready);
    end
  endtask

  task automatic test_stall();
    bus.code_ready = 1'b0;
    bus.d_in       = 8'h81;
    bus.load       = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.code_valid !== 1'b1 ||
          bus.code_out !== 3'd7 ||
          bus.count !== 4'd2) begin
        errors++;
        $display("FAIL stall[%0d] got=%b/%0d/%0d exp=1/7/2",
                 i, bus.code_valid, bus.code_out,
                 bus.count);
      end
      step();
    end
    bus.code_ready = 1'b1;
    checks++;
    if (bus.code_out !== 3'd7 || bus.count !== 4'd2) begin
      errors++;
      $display("FAIL stall_rel got=%0d/%0d exp=7/2",
               bus.code_out, bus.count);
    end
    step();
    checks++;
    if (bus.code_out !== 3'd0 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL stall_lo got=%0d/%0d exp=0/1",
               bus.code_out, bus.count);
    end
    step();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got=%b exp=1", bus.done);
    end
    step();
  endtask

  task automatic test_load_ignored();
    bus.code_ready = 1'b0;
    bus.d_in       = 8'h18;
    bus.load       = 1'b1;
    step();
    bus.d_in = 8'hFF;
    checks++;
    if (bus.code_out !== 3'd4 || bus.count !== 4'd2 ||
        bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL ign0 got=%0d/%0d/%b exp=4/2/0",
               bus.code_out, bus.count, bus.load_ready);
    end
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.code_out !== 3'd4 || bus.count !== 4'd2) begin
      errors++;
      $display("FAIL ign1 got=%0d/%0d exp=4/2",
               bus.code_out, bus.count);
    end
    bus.code_ready = 1'b1;
    step();
    checks++;
    if (bus.code_out !== 3'd3 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL ign2 got=%0d/%0d exp=3/1",
               bus.code_out, bus.count);
    end
    step();
    checks++;
    if (bus.done !== 1'b1 || bus.code_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_done got=%b/%b exp=1/0",
               bus.done, bus.code_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.code_ready = 1'b1;
    bus.d_in       = 8'hF0;
    bus.load       = 1'b1;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.code_out !== 3'd7) begin
      errors++;
      $display("FAIL mid0 got=%0d exp=7", bus.code_out);
    end
    step();
    checks++;
    if (bus.code_out !== 3'd6 || bus.count !== 4'd3) begin
      errors++;
      $display("FAIL mid1 got=%0d/%0d exp=6/3",
               bus.code_out, bus.count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.code_valid !== 1'b0 || bus.code_out !== 3'd0 ||
        bus.count !== 4'd0 || bus.load_ready !== 1'b1 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%b/%0d/%0d/%b/%b exp=0/0/0/1/0",
               bus.code_valid, bus.code_out, bus.count,
               bus.load_ready, bus.done);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone got=%b exp=0", bus.done);
    end
    rst_n = 1'b1;
    step();
    bus.d_in = 8'h02;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd1 ||
        bus.count !== 4'd1) begin
      errors++;
      $display("FAIL mid_02 got=%b/%0d/%0d exp=1/1/1",
               bus.code_valid, bus.code_out, bus.count);
    end
    step();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL mid_02_done got=%b exp=1", bus.done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    logic [2:0] exp_c [12];
    words = '{8'h11, 8'h11, 8'h90,
              8'h90, 8'h18, 8'h81};
`ifdef PENC_ROUND_ROBIN_EN
    exp_c = '{3'd4, 3'd0, 3'd4, 3'd0,
              3'd7, 3'd4, 3'd7, 3'd4,
              3'd3, 3'd4, 3'd0, 3'd7};
`else
    exp_c = '{3'd4, 3'd0, 3'd4, 3'd0,
              3'd7, 3'd4, 3'd7, 3'd4,
              3'd4, 3'd3, 3'd7, 3'd0};
`endif
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.code_ready = 1'b1;
    bus.d_in       = words[0];
    bus.load       = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.load = 1'b0;
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (bus.code_valid !== 1'b1 ||
            bus.code_out !== exp_c[2*i+j] ||
            bus.count !== 4'(2 - j)) begin
          errors++;
          $display("FAIL b2b[%0d][%0d] got=%b/%0d/%0d exp=1/%0d/%0d",
                   i, j, bus.code_valid, bus.code_out,
                   bus.count, exp_c[2*i+j], 2 - j);
        end
        step();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_done[%0d] got=%b/%b exp=1/1",
                 i, bus.done, bus.load_ready);
      end
      if (i < 5) begin
        bus.d_in = words[i+1];
        bus.load = 1'b1;
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b0 || bus.code_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got=%b/%b exp=0/0",
               bus.done, bus.code_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fixed_order();
    test_all_ones();
    test_empty();
    test_stall();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
